// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master and its divided-clock front end.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

  // Counter must hold 0 .. 2*dw (one count per SCK edge).
  function automatic int edge_cnt_width(input int dw);
    return $clog2(2 * dw + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers a level that lives in the clk domain and flags its rising/falling transitions.
// Reusable by any consumer of a divided-clock level.
module sync_edge_det #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic d_q;

  // Previous-cycle copy of the level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) d_q <= RST_VAL;
    else        d_q <= i_d;
  end

  assign o_rise = ~d_q & i_d;
  assign o_fall = d_q & ~i_d;

endmodule

// File: rtl/spi_master_ce.sv
// SPI master timed by the divided-clock level from an upstream divider.
// The divider idles high, so its falling edge is the SCK leading edge and
// its rising edge the trailing edge.
//
//   state | meaning
//   IDLE  | ready for a word, divider disabled, CS high
//   SHIFT | CS low, divider running, one SCK edge per divider transition
//   DONE  | last trailing edge seen; raise CS and publish RX word
module spi_master_ce
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_rx_valid,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_busy,
  output logic                  o_div_en,
  input  logic                  i_sclk_div,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_cs_n,
  input  logic                  i_miso
);

  localparam int            CW        = edge_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_EDGE = CW'(2 * DATA_WIDTH - 1);

  spi_state_t            state, state_nxt;
  logic                  lead, trail;
  logic                  start, in_shift, samp_edge, shift_edge, last_edge;
  logic [CW-1:0]         edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                      input logic b);
    return LSB_FIRST ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  sync_edge_det #(.RST_VAL(1'b1)) u_edge_det (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_d    (i_sclk_div),
    .o_rise (trail),
    .o_fall (lead)
  );

  assign start      = (state == IDLE) && i_valid;
  assign in_shift   = (state == SHIFT);
  assign samp_edge  = in_shift && (CPHA ? trail : lead);
  assign shift_edge = in_shift && (CPHA ? lead : trail);
  assign last_edge  = in_shift && trail && (edge_cnt == LAST_EDGE);

  assign o_ready = (state == IDLE);
  assign o_busy  = ~o_ready;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = SHIFT;
      SHIFT:   if (last_edge) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: edge counter, shift registers and registered SPI outputs.
  // For CPHA=0 the first bit goes out at capture, so tx_sr is pre-shifted
  // and each non-final trailing edge presents the next bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      edge_cnt   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
      o_div_en   <= 1'b0;
      o_sclk     <= CPOL;
      o_mosi     <= 1'b0;
      o_cs_n     <= 1'b1;
    end else begin
      o_rx_valid <= 1'b0;
      if (start) begin
        o_cs_n   <= 1'b0;
        o_div_en <= 1'b1;
        edge_cnt <= '0;
        if (CPHA) begin
          tx_sr <= i_data;
        end else begin
          tx_sr  <= shift_out(i_data);
          o_mosi <= first_bit(i_data);
        end
      end
      if (in_shift) begin
        if (lead)  o_sclk <= ~CPOL;
        if (trail) o_sclk <= CPOL;
        if (lead || trail) edge_cnt <= edge_cnt + 1'b1;
        if (samp_edge) rx_sr <= shift_in(rx_sr, i_miso);
        if (shift_edge && !last_edge) begin
          o_mosi <= first_bit(tx_sr);
          tx_sr  <= shift_out(tx_sr);
        end
        if (last_edge) o_div_en <= 1'b0;
      end
      if (state == DONE) begin
        o_cs_n     <= 1'b1;
        o_rx_data  <= rx_sr;
        o_rx_valid <= 1'b1;
      end
    end
  end

endmodule
